// File: rtl/ah_ddr2pl_reader_pkg.sv
// Shared types and AXI constants for the DDR -> PL read-back path.
package ah_ddr2pl_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_RDATA = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

   // AXI size code for a given bus width in bits
   function automatic logic [2:0] axi_size(input int data_width);
      return 3'($clog2(data_width / 8));
   endfunction

endpackage

// File: rtl/ah_ddr2pl_reader_fifo.sv
// Synchronous FIFO with fill count; head word is presented combinationally.
module ah_ddr2pl_reader_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        i_push,
   input  logic [DATA_WIDTH-1:0]       i_wdata,
   input  logic                        i_pop,
   output logic [DATA_WIDTH-1:0]       o_rdata,
   output logic                        o_empty,
   output logic [$clog2(FIFO_DEPTH):0] o_fill
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [PTR_W:0]        r_fill;
   logic                  w_do_pop;
   logic                  w_do_push;

   // Pop needs data; push at full is legal only when a pop frees the slot in the same cycle
   assign w_do_pop  = i_pop && (r_fill != '0);
   assign w_do_push = i_push && ((r_fill != FULL_CNT) || w_do_pop);

   // Storage array, no reset needed on data
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_wdata;
      end
   end

   // Pointers and occupancy
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_fill   <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_fill <= r_fill + 1'b1;
            2'b01:   r_fill <= r_fill - 1'b1;
            default: r_fill <= r_fill;
         endcase
      end
   end

   assign o_rdata = r_mem[r_rd_ptr];
   assign o_empty = (r_fill == '0);
   assign o_fill  = r_fill;

endmodule

// File: rtl/ah_ddr2pl_reader.sv
// AXI4 read master that replays a DDR region into PL logic through a credit-checked FIFO.
module ah_ddr2pl_reader
   import ah_ddr2pl_reader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int BURST_LEN  = 16,
   parameter int FIFO_DEPTH = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [31:0]           word_count,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready
);
   localparam int BYTES  = DATA_WIDTH / 8;
   localparam int FILL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int CRD_W  = FILL_W + 1;
   localparam int BEAT_W = 9;

   state_t                r_state;
   state_t                w_next;
   logic [ADDR_WIDTH-1:0] r_araddr;
   logic [7:0]            r_arlen;
   logic                  r_arvalid;
   logic [31:0]           r_remaining;
   logic [BEAT_W-1:0]     r_beats_left;
   logic [CRD_W-1:0]      r_reserved;
   logic                  r_error;

   logic [FILL_W-1:0]     w_fill;
   logic                  w_empty;
   logic                  w_pop;
   logic                  w_start_ok;
   logic                  w_r_hs;
   logic                  w_last_beat;
   logic                  w_space_ok;
   logic [BEAT_W-1:0]     w_beats;
   logic [CRD_W-1:0]      w_free;

   assign w_start_ok  = start && (r_state == ST_IDLE);
   assign w_r_hs      = (r_state == ST_RDATA) && m_axi_rvalid;
   assign w_last_beat = (r_beats_left == BEAT_W'(1));
   assign w_pop       = data_valid && data_ready;

   // Next burst size and free space once outstanding credits are subtracted
   assign w_beats    = (r_remaining >= 32'(BURST_LEN)) ? BEAT_W'(BURST_LEN) : r_remaining[BEAT_W-1:0];
   assign w_free     = CRD_W'(FIFO_DEPTH) - CRD_W'(w_fill) - r_reserved;
   assign w_space_ok = (w_free >= CRD_W'(w_beats));

   ah_ddr2pl_reader_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .i_push  (w_r_hs),
      .i_wdata (m_axi_rdata),
      .i_pop   (w_pop),
      .o_rdata (data_out),
      .o_empty (w_empty),
      .o_fill  (w_fill)
   );

   // FSM state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state; burst end is decided by the beat counter, not rlast
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (word_count == 32'd0) ? ST_DRAIN : ST_ADDR;
            end
         end
         ST_ADDR: begin
            if (r_arvalid && m_axi_arready) begin
               w_next = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (w_r_hs && w_last_beat) begin
               w_next = (r_remaining != 32'd0) ? ST_ADDR : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_empty) begin
               w_next = ST_IDLE;
            end
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // FSM outputs decoded from state; rready never stalls because space is reserved up front
   always_comb begin
      busy         = (r_state != ST_IDLE);
      done         = (r_state == ST_DRAIN) && w_empty;
      m_axi_rready = (r_state == ST_RDATA);
   end

   // Burst address, remaining words, beat counter and FIFO credit reservation
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_araddr     <= '0;
         r_arlen      <= '0;
         r_arvalid    <= 1'b0;
         r_remaining  <= '0;
         r_beats_left <= '0;
         r_reserved   <= '0;
      end else begin
         if (w_start_ok) begin
            r_araddr    <= base_addr;
            r_remaining <= word_count;
            r_reserved  <= '0;
         end else if (r_state == ST_ADDR) begin
            if (!r_arvalid) begin
               if (w_space_ok) begin
                  r_arvalid    <= 1'b1;
                  r_arlen      <= 8'(w_beats - 1'b1);
                  r_beats_left <= w_beats;
                  r_reserved   <= CRD_W'(w_beats);
               end
            end else if (m_axi_arready) begin
               r_arvalid   <= 1'b0;
               r_araddr    <= r_araddr + (ADDR_WIDTH'(r_beats_left) * ADDR_WIDTH'(BYTES));
               r_remaining <= r_remaining - 32'(r_beats_left);
            end
         end else if (w_r_hs) begin
            r_beats_left <= r_beats_left - 1'b1;
            r_reserved   <= r_reserved - 1'b1;
         end
      end
   end

   // Sticky error: bad response or rlast disagreeing with the beat count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_error <= 1'b0;
      end else if (w_start_ok) begin
         r_error <= 1'b0;
      end else if (w_r_hs) begin
         if ((m_axi_rresp != AXI_RESP_OKAY) || (m_axi_rlast != w_last_beat)) begin
            r_error <= 1'b1;
         end
      end
   end

   assign error         = r_error;
   assign data_valid    = !w_empty;
   assign m_axi_araddr  = r_araddr;
   assign m_axi_arlen   = r_arlen;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_arsize  = axi_size(DATA_WIDTH);
   assign m_axi_arburst = AXI_BURST_INCR;

endmodule

// File: tb/tb_ah_ddr2pl_reader.sv
// Bench for ah_ddr2pl_reader: AXI slave memory model, random consumer, transfer-level reference.
module tb_ah_ddr2pl_reader;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int BL = 16;
   localparam int FD = 32;
   localparam int BYTES = DW / 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [31:0]   word_count = '0;
   logic          busy, done, error;
   logic [AW-1:0] m_axi_araddr;
   logic [7:0]    m_axi_arlen;
   logic [2:0]    m_axi_arsize;
   logic [1:0]    m_axi_arburst;
   logic          m_axi_arvalid;
   logic          m_axi_arready = 1'b0;
   logic [DW-1:0] m_axi_rdata = '0;
   logic [1:0]    m_axi_rresp = 2'b00;
   logic          m_axi_rlast = 1'b0;
   logic          m_axi_rvalid = 1'b0;
   logic          m_axi_rready;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          data_ready = 1'b0;

   ah_ddr2pl_reader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .BURST_LEN  (BL),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk           (clk),
      .resetn        (resetn),
      .start         (start),
      .base_addr     (base_addr),
      .word_count    (word_count),
      .busy          (busy),
      .done          (done),
      .error         (error),
      .m_axi_araddr  (m_axi_araddr),
      .m_axi_arlen   (m_axi_arlen),
      .m_axi_arsize  (m_axi_arsize),
      .m_axi_arburst (m_axi_arburst),
      .m_axi_arvalid (m_axi_arvalid),
      .m_axi_arready (m_axi_arready),
      .m_axi_rdata   (m_axi_rdata),
      .m_axi_rresp   (m_axi_rresp),
      .m_axi_rlast   (m_axi_rlast),
      .m_axi_rvalid  (m_axi_rvalid),
      .m_axi_rready  (m_axi_rready),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .data_ready    (data_ready)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   // Observation state shared between the bus model and the tests
   bit            burst_active = 0;
   bit            r_hold = 0;
   logic [AW-1:0] b_base = '0;
   int            b_len = 0;
   int            b_idx = 0;
   int            gbeat = 0;
   int            err_beat = -1;
   int            bad_hs_cyc = -1;
   int            err_rise_cyc = -1;
   int            done_cnt = 0;
   int            done_cyc = -1;
   int            last_pop_cyc = -1;
   int            arvalid_seen = 0;
   int            hold_until = 0;
   bit            ready_rand = 0;
   int            start_cyc = 0;
   logic [AW-1:0] arq_addr[$];
   int            arq_len[$];
   logic [DW-1:0] rxq[$];
   logic [AW-1:0] exp_addr[$];
   int            exp_len[$];

   // Content of the simulated DDR at a byte address
   function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // Expected AR sequence: full bursts then a short tail
   function automatic void build_exp_ars(input logic [AW-1:0] base, input int count);
      int rem;
      int b;
      logic [AW-1:0] a;
      exp_addr.delete();
      exp_len.delete();
      rem = count;
      a = base;
      while (rem > 0) begin
         b = (rem > BL) ? BL : rem;
         exp_addr.push_back(a);
         exp_len.push_back(b - 1);
         a = a + AW'(b * BYTES);
         rem = rem - b;
      end
   endfunction

   // AXI slave, stream consumer and event recorder; all decisions made at the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!resetn) begin
            burst_active  = 0;
            r_hold        = 0;
            m_axi_rvalid  = 1'b0;
            m_axi_rlast   = 1'b0;
            m_axi_arready = 1'b0;
            data_ready    = 1'b0;
         end else begin
            if (!r_hold) begin
               if (burst_active && ($urandom_range(3) != 0)) begin
                  m_axi_rvalid = 1'b1;
                  m_axi_rdata  = mem_word(b_base + AW'(b_idx * BYTES));
                  m_axi_rlast  = (b_idx == b_len);
                  m_axi_rresp  = (gbeat == err_beat) ? 2'b10 : 2'b00;
               end else begin
                  m_axi_rvalid = 1'b0;
                  m_axi_rlast  = 1'b0;
               end
            end
            if (m_axi_rvalid && m_axi_rready) begin
               if (gbeat == err_beat) bad_hs_cyc = cyc;
               gbeat++;
               b_idx++;
               if (b_idx > b_len) burst_active = 0;
               r_hold = 0;
            end else begin
               r_hold = m_axi_rvalid;
            end

            m_axi_arready = ($urandom_range(2) != 0);
            if (m_axi_arvalid) arvalid_seen++;
            if (m_axi_arvalid && m_axi_arready) begin
               arq_addr.push_back(m_axi_araddr);
               arq_len.push_back(int'(m_axi_arlen));
               burst_active = 1;
               b_base = m_axi_araddr;
               b_len  = int'(m_axi_arlen);
               b_idx  = 0;
            end

            if (cyc < hold_until) data_ready = 1'b0;
            else data_ready = ready_rand ? ($urandom_range(3) != 0) : 1'b1;
            if (data_valid && data_ready) begin
               rxq.push_back(data_out);
               last_pop_cyc = cyc;
            end
            if (done) begin
               done_cnt++;
               done_cyc = cyc;
            end
            if (error && (err_rise_cyc < 0)) err_rise_cyc = cyc;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_obs();
      arq_addr.delete();
      arq_len.delete();
      rxq.delete();
      gbeat        = 0;
      bad_hs_cyc   = -1;
      err_rise_cyc = -1;
      done_cnt     = 0;
      done_cyc     = -1;
      last_pop_cyc = -1;
      arvalid_seen = 0;
   endtask

   task automatic start_xfer(input logic [AW-1:0] base, input int count);
      @(posedge clk); #1;
      clear_obs();
      base_addr  = base;
      word_count = count;
      start      = 1'b1;
      start_cyc  = cyc;
      @(posedge clk); #1;
      start      = 1'b0;
   endtask

   task automatic wait_xfer(input int budget, output bit timed_out);
      int n = 0;
      while ((done_cnt == 0) && (n < budget)) begin
         @(posedge clk);
         n++;
      end
      timed_out = (done_cnt == 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++;
      if ({busy, done, error, m_axi_arvalid, m_axi_rready, data_valid} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b want 000000", {busy, done, error, m_axi_arvalid, m_axi_rready, data_valid});
      end
      n_tests++;
      if (m_axi_araddr !== '0 || m_axi_arlen !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_ar: araddr %h arlen %0d want 0/0", m_axi_araddr, m_axi_arlen);
      end
      n_tests++;
      if (m_axi_arsize !== 3'd2 || m_axi_arburst !== 2'b01) begin
         n_fail++;
         $display("FAIL ar_const: arsize %0d arburst %b want 2/01", m_axi_arsize, m_axi_arburst);
      end
      resetn = 1'b1;
   endtask

   task automatic test_single_burst();
      bit to;
      logic [AW-1:0] base = 32'h1000_0000;
      ready_rand = 0;
      start_xfer(base, 16);
      wait_xfer(2000, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL single_timeout: no done within budget"); end
      n_tests++;
      if (arq_addr.size() != 1 || arq_addr[0] !== base || arq_len[0] != 15) begin
         n_fail++;
         $display("FAIL single_ar: n=%0d addr=%h len=%0d want 1/%h/15", arq_addr.size(),
                  arq_addr.size() > 0 ? arq_addr[0] : '0, arq_len.size() > 0 ? arq_len[0] : -1, base);
      end
      n_tests++;
      if (rxq.size() != 16) begin n_fail++; $display("FAIL single_count: got %0d want 16", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < 16; i++) begin
         n_tests++;
         if (rxq[i] !== mem_word(base + AW'(i * BYTES))) begin
            n_fail++;
            $display("FAIL single_word[%0d]: got %h want %h", i, rxq[i], mem_word(base + AW'(i * BYTES)));
         end
      end
      n_tests++;
      if (done_cnt != 1 || done_cyc != last_pop_cyc + 1) begin
         n_fail++;
         $display("FAIL single_done: pulses %0d at %0d, last pop %0d; want 1 pulse at last pop + 1",
                  done_cnt, done_cyc, last_pop_cyc);
      end
      n_tests++;
      if (busy !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: busy %b error %b want 0/0", busy, error);
      end
   endtask

   task automatic test_multi_burst();
      bit to;
      logic [AW-1:0] base = 32'h2000_0400;
      ready_rand = 1;
      build_exp_ars(base, 40);
      start_xfer(base, 40);
      wait_xfer(3000, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL multi_timeout: no done within budget"); end
      n_tests++;
      if (arq_addr.size() != exp_addr.size()) begin
         n_fail++;
         $display("FAIL multi_ar_count: got %0d want %0d", arq_addr.size(), exp_addr.size());
      end
      for (int i = 0; i < arq_addr.size() && i < exp_addr.size(); i++) begin
         n_tests++;
         if (arq_addr[i] !== exp_addr[i] || arq_len[i] != exp_len[i]) begin
            n_fail++;
            $display("FAIL multi_ar[%0d]: got %h/%0d want %h/%0d", i, arq_addr[i], arq_len[i], exp_addr[i], exp_len[i]);
         end
      end
      n_tests++;
      if (rxq.size() != 40) begin n_fail++; $display("FAIL multi_count: got %0d want 40", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < 40; i++) begin
         n_tests++;
         if (rxq[i] !== mem_word(base + AW'(i * BYTES))) begin
            n_fail++;
            $display("FAIL multi_word[%0d]: got %h want %h", i, rxq[i], mem_word(base + AW'(i * BYTES)));
         end
      end
      n_tests++;
      if (done_cnt != 1 || done_cyc != last_pop_cyc + 1) begin
         n_fail++;
         $display("FAIL multi_done: pulses %0d at %0d, last pop %0d", done_cnt, done_cyc, last_pop_cyc);
      end
   endtask

   task automatic test_backpressure();
      bit to;
      logic [AW-1:0] base = {$urandom} & 32'hFFFF_FFC0;
      ready_rand = 1;
      hold_until = cyc + 100;
      start_xfer(base, 64);
      while (cyc < hold_until - 1) @(posedge clk);
      #1;
      n_tests++;
      if (gbeat != FD || rxq.size() != 0) begin
         n_fail++;
         $display("FAIL bp_buffered: beats %0d popped %0d want %0d/0", gbeat, rxq.size(), FD);
      end
      n_tests++;
      if (m_axi_arvalid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_no_ar: arvalid %b want 0 while FIFO full", m_axi_arvalid);
      end
      wait_xfer(4000, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL bp_timeout: no done within budget"); end
      n_tests++;
      if (rxq.size() != 64) begin n_fail++; $display("FAIL bp_count: got %0d want 64", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < 64; i++) begin
         n_tests++;
         if (rxq[i] !== mem_word(base + AW'(i * BYTES))) begin
            n_fail++;
            $display("FAIL bp_word[%0d]: got %h want %h", i, rxq[i], mem_word(base + AW'(i * BYTES)));
         end
      end
      hold_until = 0;
   endtask

   task automatic test_rresp_error();
      bit to;
      logic [AW-1:0] base = 32'h3000_1000;
      ready_rand = 1;
      err_beat = 2;
      start_xfer(base, 24);
      wait_xfer(3000, to);
      err_beat = -1;
      n_tests++;
      if (to) begin n_fail++; $display("FAIL err_timeout: no done within budget"); end
      n_tests++;
      if (bad_hs_cyc < 0 || err_rise_cyc != bad_hs_cyc + 1) begin
         n_fail++;
         $display("FAIL err_timing: error rose at %0d, bad beat at %0d; want bad beat + 1", err_rise_cyc, bad_hs_cyc);
      end
      n_tests++;
      if (error !== 1'b1) begin n_fail++; $display("FAIL err_sticky: error %b want 1", error); end
      n_tests++;
      if (rxq.size() != 24) begin n_fail++; $display("FAIL err_count: got %0d want 24", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < 24; i++) begin
         n_tests++;
         if (rxq[i] !== mem_word(base + AW'(i * BYTES))) begin
            n_fail++;
            $display("FAIL err_word[%0d]: got %h want %h", i, rxq[i], mem_word(base + AW'(i * BYTES)));
         end
      end
      start_xfer(base + 32'h100, 8);
      n_tests++;
      if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: error %b want 0 after start", error); end
      wait_xfer(2000, to);
      n_tests++;
      if (to || error !== 1'b0 || rxq.size() != 8) begin
         n_fail++;
         $display("FAIL err_clean_xfer: timeout %b error %b words %0d want 0/0/8", to, error, rxq.size());
      end
   endtask

   task automatic test_zero_count();
      bit to;
      ready_rand = 0;
      start_xfer(32'h4000_0000, 0);
      wait_xfer(50, to);
      n_tests++;
      if (to || done_cnt != 1 || done_cyc != start_cyc + 1) begin
         n_fail++;
         $display("FAIL zero_done: timeout %b pulses %0d at %0d want 1 at %0d", to, done_cnt, done_cyc, start_cyc + 1);
      end
      n_tests++;
      if (arvalid_seen != 0 || rxq.size() != 0) begin
         n_fail++;
         $display("FAIL zero_no_ar: arvalid cycles %0d words %0d want 0/0", arvalid_seen, rxq.size());
      end
   endtask

   task automatic test_start_while_busy();
      bit to;
      logic [AW-1:0] base = 32'h5000_0080;
      ready_rand = 1;
      build_exp_ars(base, 32);
      start_xfer(base, 32);
      repeat (3) @(posedge clk);
      #1;
      base_addr  = 32'h6000_0000;
      word_count = 5;
      start      = 1'b1;
      @(posedge clk); #1;
      start      = 1'b0;
      wait_xfer(3000, to);
      n_tests++;
      if (to) begin n_fail++; $display("FAIL busy_timeout: no done within budget"); end
      n_tests++;
      if (arq_addr.size() != 2 || arq_addr[0] !== exp_addr[0] || arq_addr[1] !== exp_addr[1]) begin
         n_fail++;
         $display("FAIL busy_ignored_ar: n=%0d first=%h want 2 bursts from %h", arq_addr.size(),
                  arq_addr.size() > 0 ? arq_addr[0] : '0, base);
      end
      n_tests++;
      if (rxq.size() != 32 || rxq[31] !== mem_word(base + AW'(31 * BYTES))) begin
         n_fail++;
         $display("FAIL busy_ignored_data: words %0d want 32 from %h", rxq.size(), base);
      end
   endtask

   task automatic test_reset_mid();
      bit to;
      int n = 0;
      logic [AW-1:0] base = {$urandom} & 32'hFFFF_FFC0;
      ready_rand = 1;
      start_xfer(32'h7000_0000, 64);
      while (gbeat < 5 && n < 500) begin @(posedge clk); n++; end
      #2;
      n_tests++;
      if (gbeat < 5) begin n_fail++; $display("FAIL rstmid_progress: beats %0d want >= 5", gbeat); end
      resetn = 1'b0;
      #1;
      n_tests++;
      if ({busy, done, error, m_axi_arvalid, m_axi_rready, data_valid} !== 6'b0 ||
          m_axi_araddr !== '0 || m_axi_arlen !== 8'd0) begin
         n_fail++;
         $display("FAIL rstmid_outputs: ctrl %b araddr %h arlen %0d want all zero",
                  {busy, done, error, m_axi_arvalid, m_axi_rready, data_valid}, m_axi_araddr, m_axi_arlen);
      end
      repeat (3) @(posedge clk);
      #1;
      resetn = 1'b1;
      build_exp_ars(base, 20);
      start_xfer(base, 20);
      wait_xfer(3000, to);
      n_tests++;
      if (to || done_cnt != 1) begin
         n_fail++;
         $display("FAIL rstmid_restart_done: timeout %b pulses %0d want 0/1", to, done_cnt);
      end
      n_tests++;
      if (arq_addr.size() != 2 || arq_len[0] != 15 || arq_len[1] != 3 || arq_addr[1] !== exp_addr[1]) begin
         n_fail++;
         $display("FAIL rstmid_restart_ar: n=%0d want 2 bursts len 15,3", arq_addr.size());
      end
      n_tests++;
      if (rxq.size() != 20) begin n_fail++; $display("FAIL rstmid_count: got %0d want 20", rxq.size()); end
      for (int i = 0; i < rxq.size() && i < 20; i++) begin
         n_tests++;
         if (rxq[i] !== mem_word(base + AW'(i * BYTES))) begin
            n_fail++;
            $display("FAIL rstmid_word[%0d]: got %h want %h", i, rxq[i], mem_word(base + AW'(i * BYTES)));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_backpressure();
      test_rresp_error();
      test_zero_count();
      test_start_while_busy();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
